shapool_job: RTL and testbench

Job-controlled successor to the free-running mining pool. The block owns POOL_SIZE double-SHA256 lanes sharing one round counter and K ROM (SHA256_K). It sweeps a bounded nonce range under a start/done handshake and compares against a runtime difficulty. It reports the exact matching nonce and lane through a valid/ack result register, and it sits between the job-dispatch interface and the sha_unit datapath.

---
 rtl/shapool_pkg.sv | 88 ++++++++
 rtl/shapool_lane.sv | 63 ++++++
 rtl/shapool_job.sv | 202 ++++++++++++++++++++
 tb/tb_shapool_job.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/shapool_pkg.sv
// shapool_pkg: SHA-256 constants, padding tails, FSM encoding and round helpers
// shared by the shapool_job controller and its lanes.
package shapool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [5:0] ROUND_LAST   = 6'd63;
  localparam int         DRAIN_PASSES = 2;

  localparam logic [255:0] SHA256_H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  // Second header block after head and nonce: 80-byte message padding.
  localparam logic [383:0] M0_TAIL = {32'h80000000, 320'h0, 32'h00000280};
  localparam logic [255:0] M1_TAIL = {32'h80000000, 192'h0, 32'h00000100};

  localparam logic [2047:0] SHA256_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sha_k(input logic [5:0] r);
    return SHA256_K[2047 - 32 * int'(r) -: 32];
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s,
                                             input logic [31:0] k,
                                             input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25))
           + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22))
       + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Window holds W[t..t+15], word t in the top bits.
  function automatic logic [31:0] sha_wnext(input logic [511:0] w);
    logic [31:0] w0, w1, w9, w14;
    w0  = w[511:480];
    w1  = w[479:448];
    w9  = w[223:192];
    w14 = w[63:32];
    return (ror(w14, 17) ^ ror(w14, 19) ^ (w14 >> 10)) + w9
         + (ror(w1, 7) ^ ror(w1, 18) ^ (w1 >> 3)) + w0;
  endfunction

  function automatic logic [255:0] sha_add(input logic [255:0] x,
                                           input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255 - 8*i -: 8];
    return r;
  endfunction

endpackage

// File: rtl/shapool_lane.sv
// shapool_lane: one double-SHA256 lane (u0 header hash, u1 rehash) sharing
// the pool round counter, with a masked leading-zero difficulty compare.
module shapool_lane
  import shapool_pkg::*;
#(
  parameter int MAX_DIFFICULTY = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [5:0]   round_i,
  input  logic [255:0] midstate_i,
  input  logic [95:0]  head_i,
  input  logic [31:0]  nonce_i,
  input  logic [7:0]   diff_i,
  output logic         match_o
);

  logic [255:0] s0_q, s0_d, s1_q, s1_d;
  logic [511:0] w0_q, w0_d, w1_q, w1_d;
  logic [255:0] cs0, cs1, m1_h1, h2_sw;
  logic [511:0] cw0, cw1, m0, m1;
  logic [31:0]  k;
  logic         first;
  logic [MAX_DIFFICULTY-1:0] ones, mask;

  assign first = (round_i == 6'd0);
  assign k     = sha_k(round_i);

  // u0 finishes at the round-63 edge, so at round 0 its digest feeds u1.
  assign m0    = {head_i, bswap32(nonce_i), M0_TAIL};
  assign m1_h1 = sha_add(midstate_i, s0_q);
  assign m1    = {m1_h1, M1_TAIL};

  assign cs0 = first ? midstate_i : s0_q;
  assign cw0 = first ? m0 : w0_q;
  assign cs1 = first ? SHA256_H0 : s1_q;
  assign cw1 = first ? m1 : w1_q;

  assign s0_d = sha_round(cs0, k, cw0[511:480]);
  assign w0_d = {cw0[479:0], sha_wnext(cw0)};
  assign s1_d = sha_round(cs1, k, cw1[511:480]);
  assign w1_d = {cw1[479:0], sha_wnext(cw1)};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_q <= '0;
      w0_q <= '0;
      s1_q <= '0;
      w1_q <= '0;
    end else begin
      s0_q <= s0_d;
      w0_q <= w0_d;
      s1_q <= s1_d;
      w1_q <= w1_d;
    end
  end

  assign h2_sw   = bswap256(sha_add(SHA256_H0, s1_q));
  assign ones    = '1;
  assign mask    = ~(ones >> diff_i);
  assign match_o = ~|(h2_sw[255 -: MAX_DIFFICULTY] & mask);

endmodule

// File: rtl/shapool_job.sv
// shapool_job: job-controlled nonce sweep over POOL_SIZE lanes with a
// valid/ack result register. SHAPOOL_CONTINUE_ON_MATCH_EN sweeps past matches.
module shapool_job
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE      = 4,
  parameter int POOL_SIZE_LOG2 = 2,
  parameter int MAX_DIFFICULTY = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [255:0]               sha_state,
  input  logic [95:0]                message_head,
  input  logic [31-POOL_SIZE_LOG2:0] nonce_start,
  input  logic [31-POOL_SIZE_LOG2:0] nonce_end,
  input  logic [7:0]                 difficulty,
  output logic                       busy,
  output logic                       done,
  output logic                       exhausted,
  output logic                       result_valid,
  input  logic                       result_ack,
  output logic [31:0]                result_nonce,
  output logic [POOL_SIZE_LOG2-1:0]  result_lane,
  output logic                       result_overflow
);

  localparam int LW = 32 - POOL_SIZE_LOG2;

  state_e              state_q, state_d;
  logic [5:0]          round_q, round_d;
  logic [LW-1:0]       lower_q, lower_d, end_q;
  logic [LW-1:0]       tag1_q, tag1_d, tag2_q, tag2_d;
  logic                v1_q, v1_d, v2_q, v2_d;
  logic [1:0]          drain_q, drain_d;
  logic [7:0]          diff_q;
  logic [255:0]        mid_q;
  logic [95:0]         head_q;
  logic                done_q, done_d, exh_q, exh_d;
  logic                rv_q, rv_d, hit_q, hit_d, ovf_q, ovf_d;
  logic [31:0]         rn_q, rn_d;
  logic [POOL_SIZE_LOG2-1:0] rl_q, rl_d, hit_lane;
  logic [POOL_SIZE-1:0] match;
  logic                launch, eval, hit_now, take;

  for (genvar n = 0; n < POOL_SIZE; n++) begin : g_lane
    localparam logic [POOL_SIZE_LOG2-1:0] LID = POOL_SIZE_LOG2'(n);
    shapool_lane #(.MAX_DIFFICULTY(MAX_DIFFICULTY)) u_lane (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .round_i   (round_q),
      .midstate_i(mid_q),
      .head_i    (head_q),
      .nonce_i   ({LID, lower_q}),
      .diff_i    (diff_q),
      .match_o   (match[n])
    );
  end

  always_comb begin
    hit_lane = '0;
    for (int n = POOL_SIZE - 1; n >= 0; n--)
      if (match[n]) hit_lane = POOL_SIZE_LOG2'(n);
  end

  assign launch  = (state_q == IDLE) & start;
  assign eval    = (state_q != IDLE) & (round_q == 6'd0) & v2_q;
  assign hit_now = eval & (|match);
`ifdef SHAPOOL_CONTINUE_ON_MATCH_EN
  assign take    = hit_now & ~rv_q;
`else
  assign take    = hit_now;
`endif

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    lower_d = lower_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    exh_d   = exh_q;
    rv_d    = rv_q & ~result_ack;
    rn_d    = rn_q;
    rl_d    = rl_q;
    hit_d   = hit_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          round_d = '0;
          lower_d = nonce_start;
          v1_d    = 1'b0;
          v2_d    = 1'b0;
          drain_d = '0;
          exh_d   = 1'b0;
          rv_d    = 1'b0;
          hit_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        round_d = round_q + 6'd1;
        if (round_q == ROUND_LAST) begin
          tag2_d = tag1_q;
          v2_d   = v1_q;
          if (state_q == RUN) begin
            tag1_d = lower_q;
            v1_d   = 1'b1;
            if (lower_q == end_q) state_d = DRAIN;
            else lower_d = lower_q + LW'(1);
          end else begin
            v1_d    = 1'b0;
            drain_d = drain_q + 2'd1;
          end
        end
        if (take) begin
          rv_d = 1'b1;
          rn_d = {hit_lane, tag2_q};
          rl_d = hit_lane;
        end
        if (hit_now) begin
          hit_d = 1'b1;
`ifdef SHAPOOL_CONTINUE_ON_MATCH_EN
          if (rv_q) ovf_d = 1'b1;
`else
          state_d = IDLE;
`endif
        end
        // Second drain pass opens with the evaluation of the last nonce.
        if (state_q == DRAIN && round_q == 6'd0 &&
            drain_q == 2'(DRAIN_PASSES - 1))
          state_d = IDLE;
        if (state_d == IDLE) begin
          round_d = '0;
          done_d  = 1'b1;
          exh_d   = ~(hit_q | hit_now);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      round_q <= '0;
      lower_q <= '0;
      end_q   <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      drain_q <= '0;
      diff_q  <= '0;
      mid_q   <= '0;
      head_q  <= '0;
      done_q  <= 1'b0;
      exh_q   <= 1'b0;
      rv_q    <= 1'b0;
      rn_q    <= '0;
      rl_q    <= '0;
      hit_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      lower_q <= lower_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      exh_q   <= exh_d;
      rv_q    <= rv_d;
      rn_q    <= rn_d;
      rl_q    <= rl_d;
      hit_q   <= hit_d;
      ovf_q   <= ovf_d;
      if (launch) begin
        end_q  <= nonce_end;
        mid_q  <= sha_state;
        head_q <= message_head;
        diff_q <= (difficulty > 8'(MAX_DIFFICULTY)) ?
                  8'(MAX_DIFFICULTY) : difficulty;
      end
    end
  end

  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign exhausted       = exh_q;
  assign result_valid    = rv_q;
  assign result_nonce    = rn_q;
  assign result_lane     = rl_q;
  assign result_overflow = ovf_q;

endmodule

// File: tb/tb_shapool_job.sv
// tb_shapool_job: directed checks of shapool_job (POOL_SIZE=2) using the
// Bitcoin genesis header; midstate is computed here by a reference compressor.
module tb_shapool_job;

  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [511:0] GEN_BLK0 = {
    32'h01000000, 256'h0,
    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
    32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa};
  localparam logic [95:0] GEN_HEAD = 96'h4b1e5e4a_29ab5f49_ffff001d;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] sha_state = '0;
  logic [95:0]  message_head = '0;
  logic [30:0]  nonce_start = '0;
  logic [30:0]  nonce_end = '0;
  logic [7:0]   difficulty = '0;
  logic         result_ack = 1'b0;
  logic         busy, done, exhausted, result_valid, result_overflow;
  logic [31:0]  result_nonce;
  logic [0:0]   result_lane;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int rv_at, done_at;
  logic [255:0] mid;
  logic seen;

  shapool_job #(.POOL_SIZE(2), .POOL_SIZE_LOG2(1), .MAX_DIFFICULTY(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .sha_state(sha_state), .message_head(message_head),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .difficulty(difficulty), .busy(busy), .done(done),
    .exhausted(exhausted), .result_valid(result_valid),
    .result_ack(result_ack), .result_nonce(result_nonce),
    .result_lane(result_lane), .result_overflow(result_overflow));

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin,
                                            input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start is sampled at the edge that ends cycle 0; afterwards cyc = 1.
  task automatic launch(input logic [30:0] s, input logic [30:0] e,
                        input logic [7:0] d);
    @(negedge clk);
    sha_state = mid; message_head = GEN_HEAD;
    nonce_start = s; nonce_end = e; difficulty = d; start = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1;
    start = 1'b0;
    sha_state = ~mid; message_head = ~GEN_HEAD;
    nonce_start = ~s; nonce_end = ~e; difficulty = 8'd7;
  endtask

  task automatic run_job(input int budget, output int rva, output int dna);
    rva = -1;
    dna = -1;
    for (int i = 0; i < budget && dna < 0; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (result_valid && rva < 0) rva = cyc;
      if (done) dna = cyc;
    end
  endtask

  initial begin
    mid = compress(IV, GEN_BLK0);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rv", 64'(result_valid), 64'd0);
    chk("rst_nonce", 64'(result_nonce), 64'd0);
    chk("rst_exh", 64'(exhausted), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Genesis: 0x7C2BAC1D is pass 2, evaluated at cycle 257.
    launch(31'h7C2BAC1B, 31'h7C2BAC20, 8'd32);
    @(posedge clk); cyc++; #1;
    chk("gen_busy", 64'(busy), 64'd1);
    run_job(600, rv_at, done_at);
    chk("gen_rv_at", 64'(rv_at), 64'd258);
`ifndef SHAPOOL_CONTINUE_ON_MATCH_EN
    chk("gen_done_at", 64'(done_at), 64'd258);
    chk("gen_ovf", 64'(result_overflow), 64'd0);
`endif
    chk("gen_nonce", 64'(result_nonce), 64'h7C2BAC1D);
    chk("gen_lane", 64'(result_lane), 64'd0);
    chk("gen_exh", 64'(exhausted), 64'd0);
    chk("gen_rv", 64'(result_valid), 64'd1);
    @(negedge clk);
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
    chk("ack_rv", 64'(result_valid), 64'd0);
    chk("ack_nonce_hold", 64'(result_nonce), 64'h7C2BAC1D);

    // Four nonces per lane, none with 32 zero bits: ends after drain.
    launch(31'h0, 31'h3, 8'd32);
    run_job(600, rv_at, done_at);
    chk("exh_done_at", 64'(done_at), 64'd322);
    chk("exh_exh", 64'(exhausted), 64'd1);
    chk("exh_rv", 64'(result_valid), 64'd0);
    chk("exh_busy", 64'(busy), 64'd0);

    // Difficulty 0 matches every lane; lowest lane wins.
    launch(31'd5, 31'd5, 8'd0);
    run_job(300, rv_at, done_at);
    chk("d0_rv_at", 64'(rv_at), 64'd130);
    chk("d0_done_at", 64'(done_at), 64'd130);
    chk("d0_nonce", 64'(result_nonce), 64'd5);
    chk("d0_lane", 64'(result_lane), 64'd0);
    chk("d0_exh", 64'(exhausted), 64'd0);

    // Clamped to 64 leading zeros: nothing matches.
    launch(31'd0, 31'd0, 8'd200);
    run_job(300, rv_at, done_at);
    chk("clamp_done_at", 64'(done_at), 64'd130);
    chk("clamp_exh", 64'(exhausted), 64'd1);

    // Start while busy must not disturb the running job.
    launch(31'd5, 31'd5, 8'd0);
    repeat (9) begin @(posedge clk); cyc++; end
    @(negedge clk);
    nonce_start = 31'd9; nonce_end = 31'd9; difficulty = 8'd200; start = 1'b1;
    @(posedge clk); cyc++; #1;
    start = 1'b0;
    run_job(300, rv_at, done_at);
    chk("busy_start_rv_at", 64'(rv_at), 64'd130);
    chk("busy_start_nonce", 64'(result_nonce), 64'd5);

    // Asynchronous reset in the middle of a job.
    launch(31'h7C2BAC1B, 31'h7C2BAC20, 8'd32);
    repeat (99) begin @(posedge clk); cyc++; end
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_rv", 64'(result_valid), 64'd0);
    chk("ar_nonce", 64'(result_nonce), 64'd0);
    chk("ar_lane", 64'(result_lane), 64'd0);
    chk("ar_exh", 64'(exhausted), 64'd0);
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen |= done; end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; seen |= done; end
    chk("ar_no_done", 64'(seen), 64'd0);
    launch(31'd5, 31'd5, 8'd0);
    run_job(300, rv_at, done_at);
    chk("ar_rerun_rv_at", 64'(rv_at), 64'd130);
    chk("ar_rerun_nonce", 64'(result_nonce), 64'd5);

`ifdef SHAPOOL_CONTINUE_ON_MATCH_EN
    // Every nonce matches; only the first is kept, the rest overflow.
    launch(31'd0, 31'd3, 8'd0);
    run_job(600, rv_at, done_at);
    chk("cont_rv_at", 64'(rv_at), 64'd130);
    chk("cont_done_at", 64'(done_at), 64'd322);
    chk("cont_nonce", 64'(result_nonce), 64'd0);
    chk("cont_lane", 64'(result_lane), 64'd0);
    chk("cont_ovf", 64'(result_overflow), 64'd1);
    chk("cont_exh", 64'(exhausted), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
